// File: rtl/vga_timing_checker_if.sv
// Sync/blank stream into the checker and the recovered-timing status back out.
interface vga_timing_checker_if;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        locked;
  logic        frame_start;
  logic        err;
  logic [7:0]  err_cnt;

  // Stream source side: drives syncs/blanks, observes checker status
  modport master (
    output hsync, vsync, hblnk, vblnk,
    input  hcount, vcount, locked, frame_start, err, err_cnt
  );

  // Checker side
  modport slave (
    input  hsync, vsync, hblnk, vblnk,
    output hcount, vcount, locked, frame_start, err, err_cnt
  );
endinterface

// File: rtl/vga_timing_checker.sv
// Receive-side VGA timing checker: recovers pixel coordinates from the incoming
// sync edges, verifies every sync edge and blank level, and reports lock/errors.
module vga_timing_checker #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_TOTAL   = 1056,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_TOTAL   = 628
) (
  input  logic                clk,
  input  logic                rst,
  vga_timing_checker_if.slave vga
);
  localparam int unsigned CW = 11;
  localparam int unsigned EW = 8;

  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [EW-1:0] ERR_MAX  = EW'(255);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_H_ALIGN = 2'd1;
  localparam logic [1:0] S_V_ALIGN = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  logic          r_hs_q1, r_hs_q2;
  logic          r_vs_q1, r_vs_q2;
  logic          r_hb_q1, r_hb_q2;
  logic          r_vb_q1, r_vb_q2;

  // r_h_cnt/r_v_cnt predict the position of the q2 sample
  logic [CW-1:0] r_h_cnt, r_v_cnt;
  logic [CW-1:0] w_h_adv, w_v_adv;
  logic [CW-1:0] w_h_nxt, w_v_nxt;

  logic [CW-1:0] r_hcount, r_vcount;
  logic          r_locked, r_frame_start, r_err;
  logic [EW-1:0] r_err_cnt;

  logic          w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
  logic          w_h_wrap, w_at_vs_start, w_at_vs_end;
  logic          w_h_viol, w_v_viol, w_b_viol, w_viol;
  logic          w_locked_nxt;

  assign w_hs_rise = r_hs_q1 & ~r_hs_q2;
  assign w_hs_fall = ~r_hs_q1 & r_hs_q2;
  assign w_vs_rise = r_vs_q1 & ~r_vs_q2;
  assign w_vs_fall = ~r_vs_q1 & r_vs_q2;

  // Advanced prediction: expected position of the q1 sample
  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_h_adv  = w_h_wrap ? '0 : r_h_cnt + CW'(1);
  assign w_v_adv  = !w_h_wrap ? r_v_cnt :
                    (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CW'(1);

  assign w_at_vs_start = (w_h_adv == '0) && (w_v_adv == VS_START);
  assign w_at_vs_end   = (w_h_adv == '0) && (w_v_adv == VS_END);

  // Horizontal edges are checked in every state except SEARCH
  assign w_h_viol = (r_state != S_SEARCH) &&
                    ((w_hs_rise && (w_h_adv != HS_START)) ||
                     (w_hs_fall && (w_h_adv != HS_END))   ||
                     (!w_hs_rise && (w_h_adv == HS_START)));

  assign w_v_viol = ((r_state == S_V_ALIGN) || (r_state == S_LOCKED)) &&
                    ((w_vs_rise && !w_at_vs_start) ||
                     (w_vs_fall && !w_at_vs_end)   ||
                     (!w_vs_rise && w_at_vs_start));

  // Blank levels are compared on q2 against the q2-aligned prediction
  assign w_b_viol = (r_state == S_LOCKED) &&
                    ((r_hb_q2 != (r_h_cnt >= H_VIS)) ||
                     (r_vb_q2 != (r_v_cnt >= V_VIS)));

  assign w_viol       = w_h_viol | w_v_viol | w_b_viol;
  assign w_locked_nxt = (w_state_nxt == S_LOCKED);

  // Two-stage input capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_q1 <= 1'b0; r_hs_q2 <= 1'b0;
      r_vs_q1 <= 1'b0; r_vs_q2 <= 1'b0;
      r_hb_q1 <= 1'b0; r_hb_q2 <= 1'b0;
      r_vb_q1 <= 1'b0; r_vb_q2 <= 1'b0;
    end else begin
      r_hs_q1 <= vga.hsync; r_hs_q2 <= r_hs_q1;
      r_vs_q1 <= vga.vsync; r_vs_q2 <= r_vs_q1;
      r_hb_q1 <= vga.hblnk; r_hb_q2 <= r_hb_q1;
      r_vb_q1 <= vga.vblnk; r_vb_q2 <= r_vb_q1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_SEARCH;
    else      r_state <= w_state_nxt;
  end

  // Next state and predictor reloads; a violation always wins
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = w_h_adv;
    w_v_nxt     = w_v_adv;
    if (w_viol) begin
      if (w_hs_rise) begin
        w_state_nxt = S_H_ALIGN;
        w_h_nxt     = HS_START;
      end else begin
        w_state_nxt = S_SEARCH;
      end
    end else begin
      case (r_state)
        S_SEARCH: begin
          if (w_hs_rise) begin
            w_state_nxt = S_H_ALIGN;
            w_h_nxt     = HS_START;
          end
        end
        S_H_ALIGN: begin
          if (w_vs_rise && (w_h_adv == '0)) begin
            w_state_nxt = S_V_ALIGN;
            w_v_nxt     = VS_START;
          end
        end
        S_V_ALIGN: begin
          if (w_vs_rise) w_state_nxt = S_LOCKED;
        end
        S_LOCKED: begin
          w_state_nxt = S_LOCKED;
        end
        default: begin
          w_state_nxt = S_SEARCH;
        end
      endcase
    end
  end

  // Predictor counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
    end
  end

  // Registered status outputs; coordinates are forced to 0 while unlocked
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_err         <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_locked      <= w_locked_nxt;
      r_hcount      <= w_locked_nxt ? w_h_adv : '0;
      r_vcount      <= w_locked_nxt ? w_v_adv : '0;
      r_frame_start <= w_locked_nxt && (w_h_adv == '0) && (w_v_adv == '0);
      r_err         <= w_viol;
      if (w_viol && (r_err_cnt != ERR_MAX)) r_err_cnt <= r_err_cnt + EW'(1);
    end
  end

  assign vga.hcount      = r_hcount;
  assign vga.vcount      = r_vcount;
  assign vga.locked      = r_locked;
  assign vga.frame_start = r_frame_start;
  assign vga.err         = r_err;
  assign vga.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Bench for vga_timing_checker using a reduced frame so that several lock and
// error sequences fit in a short run.
module tb_vga_timing_checker;
  localparam int unsigned HV    = 16;
  localparam int unsigned HFP   = 4;
  localparam int unsigned HSW   = 6;
  localparam int unsigned HT    = 32;
  localparam int unsigned VV    = 10;
  localparam int unsigned VFP   = 1;
  localparam int unsigned VSW   = 2;
  localparam int unsigned VT    = 16;
  localparam int unsigned HSS   = HV + HFP;
  localparam int unsigned HSE   = HSS + HSW;
  localparam int unsigned VSS   = VV + VFP;
  localparam int unsigned VSE   = VSS + VSW;
  localparam int          FRAME = int'(HT * VT);
  localparam int          RELOCK = 2 * FRAME + 4 * int'(HT) + 32;

  logic clk;
  logic rst;

  vga_timing_checker_if vif ();

  vga_timing_checker #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_TOTAL(VT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Source position and reference-model state
  int unsigned sh = 0, sv = 0;
  bit prev_hs = 1'b0, prev_vs = 1'b0;
  int step = 0;
  int lock_at = -1;
  int need = 3;       // events still needed to lock: hsync rise, vsync rise, vsync rise
  int blind = 0;
  int obs_err = 0;
  int exp_err = 0;
  int unsigned d1h = 0, d1v = 0, d2h = 0, d2v = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_hcount"},      32'(vif.hcount), 0);
    check({pfx, "_vcount"},      32'(vif.vcount), 0);
    check({pfx, "_locked"},      32'(vif.locked), 0);
    check({pfx, "_frame_start"}, 32'(vif.frame_start), 0);
    check({pfx, "_err"},         32'(vif.err), 0);
    check({pfx, "_err_cnt"},     32'(vif.err_cnt), 0);
  endtask

  // Drive one source sample, advance one clock, then compare against the model
  task automatic src_step(input bit flip_hb, input bit stall);
    bit hs, vs, hb, vb, lk;
    hs = (sh >= HSS) && (sh < HSE);
    vs = (sv >= VSS) && (sv < VSE);
    hb = (sh >= HV) ^ flip_hb;
    vb = (sv >= VV);
    vif.hsync = hs;
    vif.vsync = vs;
    vif.hblnk = hb;
    vif.vblnk = vb;
    if (hs && !prev_hs && need == 3) need = 2;
    if (vs && !prev_vs && (need == 2 || need == 1)) begin
      need = need - 1;
      if (need == 0) lock_at = step + 2;
    end
    prev_hs = hs;
    prev_vs = vs;
    d2h = d1h; d2v = d1v;
    d1h = sh;  d1v = sv;
    if (!stall) begin
      if (sh == HT - 1) begin
        sh = 0;
        sv = (sv == VT - 1) ? 0 : sv + 1;
      end else begin
        sh = sh + 1;
      end
    end
    @(posedge clk);
    #1;
    step++;
    if (blind > 0) begin
      blind--;
      if (vif.err === 1'b1) obs_err++;
    end else begin
      lk = (lock_at >= 0) && (step >= lock_at);
      check("locked", 32'(vif.locked), 32'(lk));
      check("err_idle", 32'(vif.err), 0);
      if (lk) begin
        check("hcount", 32'(vif.hcount), d2h);
        check("vcount", 32'(vif.vcount), d2v);
        check("frame_start", 32'(vif.frame_start), 32'((d2h == 0) && (d2v == 0)));
      end else begin
        check("hcount_unlocked", 32'(vif.hcount), 0);
        check("vcount_unlocked", 32'(vif.vcount), 0);
        check("frame_start_unlocked", 32'(vif.frame_start), 0);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) src_step(1'b0, 1'b0);
  endtask

  task automatic run_to(input int unsigned v, input int unsigned h);
    while (!(sv == v && sh == h)) src_step(1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int unsigned rv, rh;
    rst       = 1'b0;
    vif.hsync = 1'b0;
    vif.vsync = 1'b0;
    vif.hblnk = 1'b0;
    vif.vblnk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Clean stream: lock on the second vsync rise, then three aligned frames
    rst = 1'b1;
    run(2 * FRAME + 3 * FRAME);
    check("clean_locked", 32'(vif.locked), 1);
    check("clean_err_cnt", 32'(vif.err_cnt), 0);

    // Horizontal blank glitch at a random point while locked
    for (int k = 0; k < 2; k++) begin
      rv = $urandom_range(VT - 1, 0);
      rh = $urandom_range(HSS - 2, 0);
      run_to(rv, rh);
      check("glitch_pre_locked", 32'(vif.locked), 1);
      need = 3; lock_at = -1; blind = 6; exp_err++;
      src_step(1'b1, 1'b0);
      run(RELOCK);
      check("glitch_err_pulses", 32'(obs_err), 32'(exp_err));
      check("glitch_err_cnt", 32'(vif.err_cnt), 32'(exp_err));
      check("glitch_relocked", 32'(vif.locked), 1);
    end

    // Source stalls one clock in the front porch: one missing-hsync error
    for (int k = 0; k < 2; k++) begin
      rv = $urandom_range(VT - 1, 0);
      rh = $urandom_range(HSS - 2, HV);
      run_to(rv, rh);
      check("stall_pre_locked", 32'(vif.locked), 1);
      need = 3; lock_at = -1; blind = 10; exp_err++;
      src_step(1'b0, 1'b1);
      run(RELOCK);
      check("stall_err_pulses", 32'(obs_err), 32'(exp_err));
      check("stall_err_cnt", 32'(vif.err_cnt), 32'(exp_err));
      check("stall_relocked", 32'(vif.locked), 1);
    end

    // Asynchronous reset mid-line clears everything before the next edge
    rv = 2;
    rh = $urandom_range(10, 1);
    run_to(rv, rh);
    check("arst_pre_locked", 32'(vif.locked), 1);
    rst = 1'b0;
    #1;
    check_all_zero("arst");
    need = 3; lock_at = -1; exp_err = 0; obs_err = 0;
    run(3);
    rst = 1'b1;
    run(RELOCK);
    check("arst_relocked", 32'(vif.locked), 1);
    check("arst_err_cnt", 32'(vif.err_cnt), 0);

    // Toggling hsync every clock produces far more than 255 violations
    vif.vsync = 1'b0;
    vif.hblnk = 1'b0;
    vif.vblnk = 1'b0;
    for (int i = 0; i < 700; i++) begin
      vif.hsync = ((i % 2) == 1);
      @(posedge clk);
      #1;
    end
    check("sat_err_cnt", 32'(vif.err_cnt), 255);
    check("sat_unlocked", 32'(vif.locked), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
